ptp_bus_master: RTL and testbench

Initiator for the 32-bit on-chip register bus used by the PTPv2 core (RTC and timestamp-unit register blocks). It accepts register read/write commands on a valid/ready command channel, drives the bus2ip strobe/address/data signals and samples ip2bus data after a fixed read latency. Results are returned on a valid/ready response channel. It sits between a host/CPU-side agent (or test sequencer) and ptpv2_core's bus port. It supports single writes and incrementing read bursts of up to 16 words.

---
 rtl/ptp_bus_pkg.sv | 30 +++
 rtl/ptp_bus_master_if.sv | 41 ++++
 rtl/ptp_bus_master.sv | 165 ++++++++++++++++
 tb/tb_ptp_bus_master.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ptp_bus_pkg.sv
// Shared types and constants for the PTPv2 register-bus initiator.
// Holds the FSM state encoding, the registered response payload and the
// bus/counter widths used by ptp_bus_master and its interface.
package ptp_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned CNT_W  = 4;

  // Byte stride between consecutive burst words
  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(4);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WSTB,
    ST_RSTB,
    ST_RWAIT,
    ST_RSP,
    ST_GAP
  } state_e;

  // Response payload held stable while rsp_valid_o is high
  typedef struct packed {
    logic              wr;
    logic              last;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

endpackage

// File: rtl/ptp_bus_master_if.sv
// Command, response and register-bus signals of ptp_bus_master.
// master : view of the initiator (accepts commands, drives bus2ip_*)
// slave  : view of the agent/slave side (issues commands, returns ip2bus data)
interface ptp_bus_master_if;
  import ptp_bus_pkg::*;

  // command channel
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_wr_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_wdata_i;
  logic [LEN_W-1:0]  cmd_len_i;
  // response channel
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic              rsp_wr_o;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_last_o;
  // register bus
  logic [ADDR_W-1:0] bus2ip_addr_o;
  logic [DATA_W-1:0] bus2ip_data_o;
  logic              bus2ip_rd_ce_o;
  logic              bus2ip_wr_ce_o;
  logic [DATA_W-1:0] ip2bus_data_i;

  modport master (
    input  cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_wdata_i, cmd_len_i,
    input  rsp_ready_i, ip2bus_data_i,
    output cmd_ready_o, rsp_valid_o, rsp_wr_o, rsp_rdata_o, rsp_last_o,
    output bus2ip_addr_o, bus2ip_data_o, bus2ip_rd_ce_o, bus2ip_wr_ce_o
  );

  modport slave (
    output cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_wdata_i, cmd_len_i,
    output rsp_ready_i, ip2bus_data_i,
    input  cmd_ready_o, rsp_valid_o, rsp_wr_o, rsp_rdata_o, rsp_last_o,
    input  bus2ip_addr_o, bus2ip_data_o, bus2ip_rd_ce_o, bus2ip_wr_ce_o
  );

endinterface

// File: rtl/ptp_bus_master.sv
// Register-bus initiator for the PTPv2 core. Accepts single writes and
// incrementing read bursts (up to 16 beats) on a valid/ready command channel,
// pulses bus2ip_wr_ce/rd_ce, samples ip2bus data RD_LATENCY cycles after the
// read strobe and returns one response per bus access.
// Ports:
//   bus2ip_clk  clock, rising edge
//   bus2ip_rst  synchronous reset, active high
//   bus         ptp_bus_master_if.master (command, response, register bus)
//   busy_o      high whenever the FSM is not idle
// All outputs are registered and decoded from the next state, so strobes and
// handshake flags are glitch-free and exactly one cycle wide where required.
module ptp_bus_master
  import ptp_bus_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                  bus2ip_clk,
  input  logic                  bus2ip_rst,
  ptp_bus_master_if.master      bus,
  output logic                  busy_o
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]  lat_q, lat_d;
  logic [CNT_W-1:0]  gap_q, gap_d;
  logic              gap_rd_q, gap_rd_d;
  rsp_t              rsp_q, rsp_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rd_ce_q, rd_ce_d;
  logic              wr_ce_q, wr_ce_d;
  logic              busy_q, busy_d;

  // State and output registers
  always_ff @(posedge bus2ip_clk) begin
    if (bus2ip_rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      lat_q       <= '0;
      gap_q       <= '0;
      gap_rd_q    <= 1'b0;
      rsp_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rd_ce_q     <= 1'b0;
      wr_ce_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      lat_q       <= lat_d;
      gap_q       <= gap_d;
      gap_rd_q    <= gap_rd_d;
      rsp_q       <= rsp_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rd_ce_q     <= rd_ce_d;
      wr_ce_q     <= wr_ce_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    lat_d    = lat_q;
    gap_d    = gap_q;
    gap_rd_d = gap_rd_q;
    rsp_d    = rsp_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    case (state_q)
      ST_IDLE: begin
        // cmd_ready_q is low in the cycle right after reset, so no accept there
        if (bus.cmd_valid_i && cmd_ready_q) begin
          addr_d = bus.cmd_addr_i;
          if (bus.cmd_wr_i) begin
            wdata_d = bus.cmd_wdata_i;
            beat_d  = '0;
            state_d = ST_WSTB;
          end else begin
            beat_d  = bus.cmd_len_i;
            state_d = ST_RSTB;
          end
        end
      end
      ST_WSTB: begin
        rsp_d.wr    = 1'b1;
        rsp_d.last  = 1'b1;
        rsp_d.rdata = '0;
        state_d     = ST_RSP;
      end
      ST_RSTB: begin
        lat_d   = CNT_W'(RD_LATENCY);
        state_d = ST_RWAIT;
      end
      ST_RWAIT: begin
        // Sample on the cycle the counter would reach zero
        if (lat_q <= CNT_W'(1)) begin
          lat_d       = '0;
          rsp_d.wr    = 1'b0;
          rsp_d.last  = (beat_q == '0);
          rsp_d.rdata = bus.ip2bus_data_i;
          state_d     = ST_RSP;
        end else begin
          lat_d = lat_q - CNT_W'(1);
        end
      end
      ST_RSP: begin
        if (bus.rsp_ready_i) begin
          if (rsp_q.last) begin
            gap_rd_d = 1'b0;
          end else begin
            gap_rd_d = 1'b1;
            addr_d   = addr_q + ADDR_INC;
            beat_d   = beat_q - LEN_W'(1);
          end
          if (GAP_CYCLES == 0) begin
            state_d = rsp_q.last ? ST_IDLE : ST_RSTB;
          end else begin
            gap_d   = CNT_W'(GAP_CYCLES);
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_q <= CNT_W'(1)) begin
          gap_d   = '0;
          state_d = gap_rd_q ? ST_RSTB : ST_IDLE;
        end else begin
          gap_d = gap_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RSP);
    rd_ce_d     = (state_d == ST_RSTB);
    wr_ce_d     = (state_d == ST_WSTB);
    busy_d      = (state_d != ST_IDLE);
  end

  assign bus.cmd_ready_o    = cmd_ready_q;
  assign bus.rsp_valid_o    = rsp_valid_q;
  assign bus.rsp_wr_o       = rsp_q.wr;
  assign bus.rsp_last_o     = rsp_q.last;
  assign bus.rsp_rdata_o    = rsp_q.rdata;
  assign bus.bus2ip_addr_o  = addr_q;
  assign bus.bus2ip_data_o  = wdata_q;
  assign bus.bus2ip_rd_ce_o = rd_ce_q;
  assign bus.bus2ip_wr_ce_o = wr_ce_q;
  assign busy_o             = busy_q;

endmodule

// File: tb/tb_ptp_bus_master.sv
// Directed self-checking bench for ptp_bus_master (RD_LATENCY=2, GAP_CYCLES=1).
module tb_ptp_bus_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  ptp_bus_master_if bus ();

  ptp_bus_master #(.RD_LATENCY(2), .GAP_CYCLES(1)) dut (
    .bus2ip_clk (clk),
    .bus2ip_rst (rst),
    .bus        (bus),
    .busy_o     (busy)
  );

  int tests = 0;
  int fails = 0;
  int bp_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Slave: valid data only two cycles after the read strobe, junk otherwise
  logic [1:0]  rd_hist = '0;
  logic [31:0] a0 = '0;
  logic [31:0] a1 = '0;

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'h1234_5678 : (a ^ 32'hA5A5_0000);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      rd_hist <= '0;
    end else begin
      rd_hist <= {rd_hist[0], bus.bus2ip_rd_ce_o};
      a0      <= bus.bus2ip_addr_o;
      a1      <= a0;
    end
  end

  assign bus.ip2bus_data_i = rd_hist[1] ? slave_data(a1) : 32'hBAD0_BAD0;

  // Strobe monitor
  int          rd_n = 0;
  int          wr_n = 0;
  int          viol = 0;
  logic        prev_stb = 1'b0;
  logic [31:0] rd_log [32];
  logic [31:0] wr_addr_log = '0;
  logic [31:0] wr_data_log = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stb = 1'b0;
    end else begin
      if (bus.bus2ip_rd_ce_o) begin
        if (rd_n < 32) rd_log[rd_n] = bus.bus2ip_addr_o;
        rd_n++;
      end
      if (bus.bus2ip_wr_ce_o) begin
        wr_addr_log = bus.bus2ip_addr_o;
        wr_data_log = bus.bus2ip_data_o;
        wr_n++;
      end
      if ((bus.bus2ip_rd_ce_o || bus.bus2ip_wr_ce_o) && prev_stb) viol++;
      if (bus.bus2ip_rd_ce_o && bus.bus2ip_wr_ce_o) viol++;
      prev_stb = bus.bus2ip_rd_ce_o | bus.bus2ip_wr_ce_o;
    end
  end

  // Present a command at a negedge; return at the negedge after the accept edge
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] len, input string tag);
    int n = 0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_wr_i    = wr;
    bus.cmd_addr_i  = addr;
    bus.cmd_wdata_i = wdata;
    bus.cmd_len_i   = len;
    while (!bus.cmd_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check1({tag, "_accept"}, bus.cmd_ready_o, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    bus.cmd_wdata_i = 32'hFFFF_FFFF;
    bus.cmd_addr_i  = 32'hFFFF_FFFF;
  endtask

  // Wait for a response, optionally hold off rsp_ready, then accept it
  task automatic wait_rsp(input logic exp_wr, input logic [31:0] exp_rdata, input logic exp_last,
                          input int hold, input string tag);
    int n = 0;
    logic [31:0] snap;
    logic snap_last;
    while (!bus.rsp_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check1({tag, "_valid"}, bus.rsp_valid_o, 1'b1);
    snap      = bus.rsp_rdata_o;
    snap_last = bus.rsp_last_o;
    repeat (hold) begin
      @(negedge clk);
      if (!bus.rsp_valid_o || bus.rsp_rdata_o !== snap || bus.rsp_last_o !== snap_last ||
          bus.cmd_ready_o || bus.bus2ip_rd_ce_o || bus.bus2ip_wr_ce_o)
        bp_bad++;
    end
    check1({tag, "_wr"}, bus.rsp_wr_o, exp_wr);
    check ({tag, "_rdata"}, bus.rsp_rdata_o, exp_rdata);
    check1({tag, "_last"}, bus.rsp_last_o, exp_last);
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int seen;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_wr_i    = 1'b0;
    bus.cmd_addr_i  = '0;
    bus.cmd_wdata_i = '0;
    bus.cmd_len_i   = '0;
    bus.rsp_ready_i = 1'b0;

    // Reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check1("rst_cmd_ready", bus.cmd_ready_o, 1'b0);
    check1("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
    check1("rst_rd_ce", bus.bus2ip_rd_ce_o, 1'b0);
    check1("rst_wr_ce", bus.bus2ip_wr_ce_o, 1'b0);
    check ("rst_addr", bus.bus2ip_addr_o, 32'h0);
    check1("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check1("post_rst_cmd_ready", bus.cmd_ready_o, 1'b1);

    // Single write
    issue(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'd0, "wr1");
    check1("wr1_wr_ce", bus.bus2ip_wr_ce_o, 1'b1);
    check1("wr1_rd_ce", bus.bus2ip_rd_ce_o, 1'b0);
    check ("wr1_addr", bus.bus2ip_addr_o, 32'h0000_0104);
    check ("wr1_data", bus.bus2ip_data_o, 32'hDEAD_BEEF);
    check1("wr1_cmd_ready", bus.cmd_ready_o, 1'b0);
    check1("wr1_busy", busy, 1'b1);
    wait_rsp(1'b1, 32'h0, 1'b1, 0, "wr1");
    check("wr1_strobes", 32'(wr_n), 32'd1);
    check("wr1_log_addr", wr_addr_log, 32'h0000_0104);
    check("wr1_log_data", wr_data_log, 32'hDEAD_BEEF);

    // Single read
    issue(1'b0, 32'h0000_0100, 32'h0, 4'd0, "rd1");
    check1("rd1_rd_ce", bus.bus2ip_rd_ce_o, 1'b1);
    check ("rd1_addr", bus.bus2ip_addr_o, 32'h0000_0100);
    wait_rsp(1'b0, 32'h1234_5678, 1'b1, 0, "rd1");
    check("rd1_data_held", bus.bus2ip_data_o, 32'hDEAD_BEEF);

    // Burst of 4 with back-pressure on the second beat
    base = rd_n;
    issue(1'b0, 32'h0000_0200, 32'h0, 4'd3, "burst");
    wait_rsp(1'b0, 32'hA5A5_0200, 1'b0, 0,  "b0");
    wait_rsp(1'b0, 32'hA5A5_0204, 1'b0, 10, "b1");
    wait_rsp(1'b0, 32'hA5A5_0208, 1'b0, 0,  "b2");
    wait_rsp(1'b0, 32'hA5A5_020C, 1'b1, 0,  "b3");
    check("bp_stable", 32'(bp_bad), 32'd0);
    check("burst_strobes", 32'(rd_n - base), 32'd4);
    check("burst_a0", rd_log[base],     32'h0000_0200);
    check("burst_a1", rd_log[base + 1], 32'h0000_0204);
    check("burst_a2", rd_log[base + 2], 32'h0000_0208);
    check("burst_a3", rd_log[base + 3], 32'h0000_020C);

    // Address wrap
    base = rd_n;
    issue(1'b0, 32'hFFFF_FFFC, 32'h0, 4'd1, "wrap");
    wait_rsp(1'b0, 32'h5A5A_FFFC, 1'b0, 0, "w0");
    wait_rsp(1'b0, 32'hA5A5_0000, 1'b1, 0, "w1");
    check("wrap_strobes", 32'(rd_n - base), 32'd2);
    check("wrap_a0", rd_log[base],     32'hFFFF_FFFC);
    check("wrap_a1", rd_log[base + 1], 32'h0000_0000);

    // Reset during RWAIT
    issue(1'b0, 32'h0000_0300, 32'h0, 4'd0, "rrst");
    @(negedge clk);
    check1("rrst_busy_rwait", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check1("rrst_rsp_valid", bus.rsp_valid_o, 1'b0);
    check1("rrst_busy", busy, 1'b0);
    check1("rrst_cmd_ready", bus.cmd_ready_o, 1'b0);
    check1("rrst_rd_ce", bus.bus2ip_rd_ce_o, 1'b0);
    check ("rrst_addr", bus.bus2ip_addr_o, 32'h0);
    check ("rrst_data", bus.bus2ip_data_o, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check1("rrst_ready_back", bus.cmd_ready_o, 1'b1);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid_o) seen++;
    end
    check("rrst_dropped", 32'(seen), 32'd0);

    issue(1'b1, 32'h0000_0108, 32'h0BAD_F00D, 4'd0, "wr2");
    check1("wr2_wr_ce", bus.bus2ip_wr_ce_o, 1'b1);
    check ("wr2_addr", bus.bus2ip_addr_o, 32'h0000_0108);
    check ("wr2_data", bus.bus2ip_data_o, 32'h0BAD_F00D);
    wait_rsp(1'b1, 32'h0, 1'b1, 0, "wr2");

    repeat (3) @(negedge clk);
    check("strobe_rules", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
